labfinal_difficulty_ctrl: RTL and testbench
===========================================

// Module: labfinal_difficulty_ctrl
// PURPOSE
//  Difficulty-selection controller for the final-project SoC. Debounces two board
//  buttons (NEXT, CONFIRM), steps a wrapping difficulty level, and drives the 1-bit
//  difficulty_selected flag read by the NIOS through the difficulty PIO. Exposes an
//  Avalon-MM slave (status/level/edge/mask) and a level-sensitive irq to the CPU.
// PARAMETERS
//  NUM_LEVELS    3        number of difficulty levels, 2..16
//  LEVEL_W       4        width of level field; 2**LEVEL_W >= NUM_LEVELS
//  DEFAULT_LEVEL 0        level after reset and after game_over return
//  DEB_CYCLES    500000   cycles a synced input must hold stable to be accepted (>=2)
// PORTS
//  clk                  in   1        system clock
//  reset_n              in   1        asynchronous, active-low reset
//  address              in   2        Avalon word address
//  chipselect           in   1        Avalon slave select
//  write_n              in   1        Avalon write strobe, active-low
//  writedata            in   32       Avalon write data
//  readdata             out  32       Avalon read data, registered
//  irq                  out  1        interrupt, registered, level-high
//  btn_next             in   1        raw async button, high = pressed
//  btn_confirm          in   1        raw async button, high = pressed
//  game_over            in   1        synchronous pulse from game logic, 1 cycle
//  difficulty_selected  out  1        high while ARMED; feeds PIO in_port
//  level                out  LEVEL_W  current difficulty level
// BEHAVIOUR
//  Reset: state=SELECT, level=DEFAULT_LEVEL, edge=0, mask=0, readdata=0, irq=0,
//   difficulty_selected=0, debouncers cleared (debounced value 0, counter 0).
//  Input conditioning: each button -> 2-FF sync -> stable counter; debounced value
//   updates only after DEB_CYCLES consecutive equal samples; rising edge of the
//   debounced value yields a 1-cycle pulse (nxt_p / cfm_p). Press-to-pulse latency
//   = 2 + DEB_CYCLES + 1 cycles. Glitches shorter than DEB_CYCLES produce no pulse.
//  FSM (2 states):
//   SELECT: nxt_p -> level = (level==NUM_LEVELS-1) ? 0 : level+1.
//           cfm_p -> ARMED next cycle; edge[0] set. cfm_p and nxt_p same cycle:
//           confirm wins, level unchanged.
//   ARMED : difficulty_selected=1 (registered, asserted the cycle state=ARMED);
//           nxt_p, cfm_p ignored; level write ignored.
//           game_over -> SELECT, level=DEFAULT_LEVEL, edge[1] set.
//   SW abort: write CTRL bit0=1 in any state -> SELECT, level unchanged; wins over
//           cfm_p/game_over in the same cycle (their edge bits still set).
//   game_over in SELECT: ignored, no edge bit.
//  Register map (access when chipselect=1):
//   0 STATUS  R  : [0]=state(1=ARMED) [LEVEL_W+3:4]=level; write: bit0=SW abort
//   1 LEVEL   RW : [LEVEL_W-1:0]; write accepted only in SELECT and only if
//                  value < NUM_LEVELS, else dropped; same-cycle nxt_p ignored (write wins)
//   2 EDGE    RW1C: [1:0] event bits; HW set wins over same-cycle SW clear
//   3 MASK    RW : [1:0] irq enables
//  Unused bits read 0. readdata updated every clock from address (no read strobe),
//   1-cycle latency, no wait states. irq <= |(edge & mask), 1 cycle after edge/mask.
//  level out: registered, changes 1 cycle after nxt_p / write / game_over.
//  Reset mid-debounce or mid-ARMED: immediately returns to reset values; a button
//   held through reset release must be seen stable DEB_CYCLES before its value is
//   accepted; a held button produces a pulse only on its rising debounced edge.
// STRUCTURE
//  Package labfinal_diff_pkg: state encoding (SELECT=1'b0, ARMED=1'b1), register
//   address constants, EDGE bit indices (EV_CONFIRM=0, EV_GAMEOVER=1).
//  Sub-module labfinal_debounce (params DEB_CYCLES): sync, stable counter, rise
//   pulse; instantiated twice. Top holds FSM, level counter, Avalon regs, irq.
// TESTING (bench uses DEB_CYCLES=4, NUM_LEVELS=3)
//  Reset: readdata=0, irq=0, level=0, difficulty_selected=0 on first cycle after release.
//  btn_next 3-cycle glitch -> no level change; 3 clean presses -> level 1,2,0 (wrap).
//  btn_next and btn_confirm rise together -> ARMED, level unchanged, EDGE reads 2'b01.
//  MASK=3, confirm -> irq=1; write EDGE=1 -> irq=0 next cycle; game_over -> level=0,
//   difficulty_selected=0, EDGE=2'b10, irq=1.
//  Write LEVEL=2 in SELECT -> level=2; LEVEL=3 -> dropped; LEVEL=1 while ARMED -> dropped.
//  ARMED, write STATUS=1 same cycle as game_over -> SELECT, level stays 2, EDGE[1]=1.

Source files
------------

// File: rtl/labfinal_diff_pkg.sv
// Shared types and constants for the difficulty-selection controller.
// State encoding, Avalon register addresses and EDGE bit positions.
package labfinal_diff_pkg;

  typedef enum logic {
    SELECT = 1'b0,
    ARMED  = 1'b1
  } state_e;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_LEVEL  = 2'd1;
  localparam logic [1:0] REG_EDGE   = 2'd2;
  localparam logic [1:0] REG_MASK   = 2'd3;

  localparam int EV_CONFIRM  = 0;
  localparam int EV_GAMEOVER = 1;

endpackage

// File: rtl/labfinal_debounce.sv
// Button conditioner: 2-FF sync, stability counter, rising-edge pulse.
// The debounced value moves only after DEB_CYCLES consecutive differing samples.
module labfinal_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Accept the synced value once it differs from deb for DEB_CYCLES samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (s2 == deb) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      cnt <= '0;
      deb <= s2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // One-cycle registered pulse on the debounced rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      deb_q <= deb;
      pulse <= deb & ~deb_q;
    end
  end

endmodule

// File: rtl/labfinal_difficulty_ctrl.sv
// Difficulty-selection controller: button debounce, SELECT/ARMED FSM,
// wrapping level counter, Avalon-MM register slave and level irq.
module labfinal_difficulty_ctrl
  import labfinal_diff_pkg::*;
#(
  parameter int NUM_LEVELS    = 3,
  parameter int LEVEL_W       = 4,
  parameter int DEFAULT_LEVEL = 0,
  parameter int DEB_CYCLES    = 500000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq,
  input  logic               btn_next,
  input  logic               btn_confirm,
  input  logic               game_over,
  output logic               difficulty_selected,
  output logic [LEVEL_W-1:0] level
);

  state_e             state;
  logic [1:0]         ev_q;
  logic [1:0]         mask;
  logic               nxt_p;
  logic               cfm_p;
  logic               wr;
  logic               abort;
  logic               lvl_wr;
  logic [LEVEL_W-1:0] wd_lvl;
  logic [LEVEL_W-1:0] lvl_inc;
  logic [1:0]         ev_set;
  logic [1:0]         ev_clr;
  logic [31:0]        rd_mux;
  logic               unused_wd;

  labfinal_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_next),
    .pulse   (nxt_p)
  );

  labfinal_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cfm (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_confirm),
    .pulse   (cfm_p)
  );

  assign unused_wd = ^writedata[31:LEVEL_W];
  assign wr        = chipselect & ~write_n;
  assign wd_lvl    = writedata[LEVEL_W-1:0];
  assign abort     = wr && (address == REG_STATUS) && writedata[0];
  assign lvl_wr    = wr && (address == REG_LEVEL) && (state == SELECT)
                     && (32'(wd_lvl) < 32'(NUM_LEVELS));
  assign lvl_inc   = (level == LEVEL_W'(NUM_LEVELS - 1)) ? '0
                     : level + LEVEL_W'(1);

  // Event sources: confirm only counts in SELECT, game_over only in ARMED.
  always_comb begin
    ev_set              = '0;
    ev_set[EV_CONFIRM]  = cfm_p && (state == SELECT);
    ev_set[EV_GAMEOVER] = game_over && (state == ARMED);
    ev_clr              = '0;
    if (wr && (address == REG_EDGE)) ev_clr = writedata[1:0];
  end

  // FSM, level counter and registered difficulty_selected flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= SELECT;
      level               <= LEVEL_W'(DEFAULT_LEVEL);
      difficulty_selected <= 1'b0;
    end else begin
      unique case (state)
        SELECT: begin
          if (cfm_p && !abort) begin
            state               <= ARMED;
            difficulty_selected <= 1'b1;
          end
          if (lvl_wr) begin
            level <= wd_lvl;
          end else if (nxt_p && !cfm_p) begin
            level <= lvl_inc;
          end
        end
        ARMED: begin
          if (abort) begin
            state               <= SELECT;
            difficulty_selected <= 1'b0;
          end else if (game_over) begin
            state               <= SELECT;
            difficulty_selected <= 1'b0;
            level               <= LEVEL_W'(DEFAULT_LEVEL);
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

  // EDGE (hardware set beats same-cycle clear) and MASK registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_q <= '0;
      mask <= '0;
    end else begin
      ev_q <= (ev_q & ~ev_clr) | ev_set;
      if (wr && (address == REG_MASK)) mask <= writedata[1:0];
    end
  end

  // Read mux; unused bits stay zero.
  always_comb begin
    rd_mux = '0;
    unique case (address)
      REG_STATUS: begin
        rd_mux[0]           = (state == ARMED);
        rd_mux[LEVEL_W+3:4] = level;
      end
      REG_LEVEL: rd_mux[LEVEL_W-1:0] = level;
      REG_EDGE:  rd_mux[1:0]         = ev_q;
      REG_MASK:  rd_mux[1:0]         = mask;
      default:   rd_mux              = '0;
    endcase
  end

  // Registered read data and interrupt line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= |(ev_q & mask);
    end
  end

endmodule

// File: tb/tb_labfinal_difficulty_ctrl.sv
// Self-checking bench for labfinal_difficulty_ctrl (DEB_CYCLES=4, 3 levels).
// Vector table for the main flow, hand sequences for reset corner cases.
module tb_labfinal_difficulty_ctrl;

  localparam int D  = 4;
  localparam int LW = 4;

  typedef enum int {
    OP_RD, OP_WR, OP_NEXT, OP_CFM, OP_BOTH, OP_GLITCH, OP_GO, OP_ABGO
  } op_e;

  typedef struct {
    op_e         op;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [3:0]  lvl;
    logic        dsel;
    logic        irq;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;
  logic          btn_next = 1'b0;
  logic          btn_confirm = 1'b0;
  logic          game_over = 1'b0;
  logic          difficulty_selected;
  logic [LW-1:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[$];

  labfinal_difficulty_ctrl #(
    .NUM_LEVELS(3), .LEVEL_W(LW), .DEFAULT_LEVEL(0), .DEB_CYCLES(D)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .address             (address),
    .chipselect          (chipselect),
    .write_n             (write_n),
    .writedata           (writedata),
    .readdata            (readdata),
    .irq                 (irq),
    .btn_next            (btn_next),
    .btn_confirm         (btn_confirm),
    .game_over           (game_over),
    .difficulty_selected (difficulty_selected),
    .level               (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input op_e op, input logic [1:0] a,
                     input logic [31:0] d, input logic [3:0] l,
                     input logic ds, input logic iq);
    vec_t v;
    v.op = op; v.addr = a; v.data = d;
    v.lvl = l; v.dsel = ds; v.irq = iq;
    vecs.push_back(v);
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] e,
                         input string nm);
    @(negedge clk);
    address = a;
    chipselect = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk(nm, readdata, exp_q.pop_front());
    chipselect = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d,
                          input logic go);
    @(negedge clk);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    game_over = go;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
    game_over = 1'b0;
  endtask

  task automatic press(input logic n, input logic c, input int hold);
    @(negedge clk);
    btn_next = n;
    btn_confirm = c;
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    btn_confirm = 1'b0;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic pulse_go();
    @(negedge clk);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
  endtask

  initial begin
    // op, addr, data, level, dsel, irq (rd expectation in data for OP_RD)
    add(OP_RD,     2'd0, 32'h0,  0, 0, 0);
    add(OP_GLITCH, 2'd0, 32'h0,  0, 0, 0);
    add(OP_NEXT,   2'd0, 32'h0,  1, 0, 0);
    add(OP_NEXT,   2'd0, 32'h0,  2, 0, 0);
    add(OP_NEXT,   2'd0, 32'h0,  0, 0, 0);
    add(OP_WR,     2'd1, 32'h2,  2, 0, 0);
    add(OP_WR,     2'd1, 32'h3,  2, 0, 0);
    add(OP_RD,     2'd1, 32'h2,  2, 0, 0);
    add(OP_WR,     2'd3, 32'h3,  2, 0, 0);
    add(OP_BOTH,   2'd0, 32'h0,  2, 1, 1);
    add(OP_RD,     2'd2, 32'h1,  2, 1, 1);
    add(OP_RD,     2'd0, 32'h21, 2, 1, 1);
    add(OP_WR,     2'd1, 32'h1,  2, 1, 1);
    add(OP_NEXT,   2'd0, 32'h0,  2, 1, 1);
    add(OP_WR,     2'd2, 32'h1,  2, 1, 0);
    add(OP_GO,     2'd0, 32'h0,  0, 0, 1);
    add(OP_RD,     2'd2, 32'h2,  0, 0, 1);
    add(OP_WR,     2'd2, 32'h2,  0, 0, 0);
    add(OP_GO,     2'd0, 32'h0,  0, 0, 0);
    add(OP_RD,     2'd2, 32'h0,  0, 0, 0);
    add(OP_WR,     2'd1, 32'h2,  2, 0, 0);
    add(OP_CFM,    2'd0, 32'h0,  2, 1, 1);
    add(OP_WR,     2'd2, 32'h3,  2, 1, 0);
    add(OP_ABGO,   2'd0, 32'h1,  2, 0, 1);
    add(OP_RD,     2'd2, 32'h2,  2, 0, 1);
    add(OP_RD,     2'd0, 32'h20, 2, 0, 1);
    add(OP_RD,     2'd3, 32'h3,  2, 0, 1);
    add(OP_WR,     2'd0, 32'h1,  2, 0, 1);

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst readdata", readdata, 32'h0);
    chk("rst irq", 32'(irq), 32'h0);
    chk("rst level", 32'(level), 32'h0);
    chk("rst dsel", 32'(difficulty_selected), 32'h0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      unique case (v.op)
        OP_RD:     do_read(v.addr, v.data, $sformatf("v%0d readdata", i));
        OP_WR:     do_write(v.addr, v.data, 1'b0);
        OP_ABGO:   do_write(2'd0, v.data, 1'b1);
        OP_NEXT:   press(1'b1, 1'b0, D + 6);
        OP_CFM:    press(1'b0, 1'b1, D + 6);
        OP_BOTH:   press(1'b1, 1'b1, D + 6);
        OP_GLITCH: press(1'b1, 1'b0, 3);
        OP_GO:     pulse_go();
        default:   ;
      endcase
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d level", i), 32'(level), 32'(v.lvl));
      chk($sformatf("v%0d dsel", i), 32'(difficulty_selected),
          32'(v.dsel));
      chk($sformatf("v%0d irq", i), 32'(irq), 32'(v.irq));
    end

    // Reset while ARMED with NEXT held through reset release.
    press(1'b0, 1'b1, D + 6);
    chk("armed dsel", 32'(difficulty_selected), 32'h1);
    @(negedge clk);
    btn_next = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("async level", 32'(level), 32'h0);
    chk("async dsel", 32'(difficulty_selected), 32'h0);
    chk("async irq", 32'(irq), 32'h0);
    chk("async readdata", readdata, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("held early", 32'(level), 32'h0);
    repeat (D + 6) @(negedge clk);
    chk("held pulse", 32'(level), 32'h1);
    repeat (20) @(negedge clk);
    chk("held once", 32'(level), 32'h1);
    btn_next = 1'b0;
    repeat (D + 6) @(negedge clk);
    chk("release", 32'(level), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
